// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   rx_state_t      receiver FSM state encoding
//   PAR_MODE_*      parity-mode constants (value of the PARITY_ODD parameter)
//   parity_error()  maps the XOR of data+parity bits to an error flag
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam logic PAR_MODE_EVEN = 1'b0;
  localparam logic PAR_MODE_ODD  = 1'b1;

  // i_xor is the XOR over all data bits and the parity bit.
  // Odd parity expects 1, even parity expects 0.
  function automatic logic parity_error(input logic i_xor, input logic i_odd);
    return i_odd ? ~i_xor : i_xor;
  endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// uart_rx_ovs_if: receiver output channel (valid/ready with status flags).
//   o_data        received word
//   o_valid       word and flags hold an unconsumed frame
//   i_ready       consumer accepts on o_valid && i_ready
//   o_parity_err, o_frame_err, o_break, o_overrun : status, qualified by o_valid
// master = receiver side, slave = consumer side.
interface uart_rx_ovs_if #(
  parameter int N_DATA = 8
) ();
  logic [N_DATA-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_parity_err;
  logic              o_frame_err;
  logic              o_break;
  logic              o_overrun;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input.
//   i_clock  clock
//   i_reset  synchronous active-high reset, loads both flops with RST_VAL
//   i_d      asynchronous input
//   o_q      synchronized output
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);
  logic r_ff1;
  logic r_ff2;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ff1 <= RST_VAL;
      r_ff2 <= RST_VAL;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;
endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with registered valid/ready output.
//   i_clock  clock, rising edge
//   i_reset  synchronous active-high reset
//   i_tick   oversampling strobe, OVS pulses per bit period
//   i_rx     asynchronous serial line, idle high
//   rx_if    output channel (master): data, valid, ready, status flags
// The FSM only advances on i_tick cycles and never stalls on the output
// register; a frame completing while the previous one is still held and
// not accepted is dropped and flagged as overrun.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int N_DATA     = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 1,
  parameter int M_STOP     = 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_tick,
  input  logic          i_rx,
  uart_rx_ovs_if.master rx_if
);
  localparam int CNT_W = $clog2(OVS);
  localparam int IDX_W = 4;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(N_DATA - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(M_STOP - 1);
  localparam logic ODD_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

  logic w_rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  rx_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [N_DATA-1:0] r_shift, w_shift_nxt;
  logic              r_par, w_par_nxt;
  logic              r_ferr, w_ferr_nxt;
  logic              w_done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_ferr_nxt  = r_ferr;
    w_done      = 1'b0;
    if (i_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = ST_START;
            w_cnt_nxt   = '0;
          end
        end
        ST_START: begin
          // Re-check the line half a bit in; a high level there is a glitch.
          if (r_cnt == CNT_HALF) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = '0;
            w_par_nxt  = 1'b0;
            w_ferr_nxt = 1'b0;
            w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {w_rx_s, r_shift[N_DATA-1:1]};  // LSB arrives first
            if (r_idx == IDX_DATA_LAST) begin
              w_idx_nxt   = '0;
              w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_par_nxt   = w_rx_s;
            w_state_nxt = ST_STOP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            if (!w_rx_s) w_ferr_nxt = 1'b1;
            if (r_idx == IDX_STOP_LAST) begin
              w_done      = 1'b1;
              w_idx_nxt   = '0;
              w_state_nxt = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (w_rx_s) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status of the completing frame; the final stop sample is folded in live.
  logic w_frame_ferr;
  logic w_frame_perr;
  logic w_frame_brk;

  assign w_frame_ferr = r_ferr | ~w_rx_s;
  assign w_frame_perr = (PARITY_EN != 0) ? parity_error(^{r_shift, r_par}, ODD_MODE) : 1'b0;
  assign w_frame_brk  = w_frame_ferr && (r_shift == '0) && !r_par;

  logic [N_DATA-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr_o;
  logic              r_brk;
  logic              r_overrun;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_brk     <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || rx_if.i_ready) begin
        r_data    <= r_shift;
        r_valid   <= 1'b1;
        r_perr    <= w_frame_perr;
        r_ferr_o  <= w_frame_ferr;
        r_brk     <= w_frame_brk;
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= 1'b1;  // held word is kept, new word is lost
      end
    end else if (r_valid && rx_if.i_ready) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign rx_if.o_data       = r_data;
  assign rx_if.o_valid      = r_valid;
  assign rx_if.o_parity_err = r_perr;
  assign rx_if.o_frame_err  = r_ferr_o;
  assign rx_if.o_break      = r_brk;
  assign rx_if.o_overrun    = r_overrun;
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: table-driven, directed and randomized checks of uart_rx_ovs
// with default parameters (8 data bits, OVS=16, odd parity, 1 stop bit).
// i_tick is pulsed every 4th clock, so one bit lasts 64 clocks.
module tb_uart_rx_ovs;
  localparam int BIT_CLK = 16 * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rx = 1'b1;

  uart_rx_ovs_if #(.N_DATA(8)) rx_if ();

  uart_rx_ovs dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_tick  (tick),
    .i_rx    (rx),
    .rx_if   (rx_if)
  );

  always #5 clk = ~clk;

  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = tcnt + 1;
      tick = (tcnt % 4 == 0);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    logic       ovr;
  } obs_t;

  obs_t obs_q[$];

  // Record every accepted word (handshake seen at the coming edge).
  always @(negedge clk) begin
    if (!rst && rx_if.o_valid && rx_if.i_ready) begin
      obs_t o;
      o.data = rx_if.o_data;
      o.perr = rx_if.o_parity_err;
      o.ferr = rx_if.o_frame_err;
      o.brk  = rx_if.o_break;
      o.ovr  = rx_if.o_overrun;
      obs_q.push_back(o);
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    rx = 1'b1;
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d,
                              input logic perr, input logic ferr, input logic brk,
                              input logic ovr);
    chk({name, " count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      obs_t o;
      o = obs_q.pop_front();
      chk({name, " data"}, o.data, d);
      chk({name, " perr"}, o.perr, perr);
      chk({name, " ferr"}, o.ferr, ferr);
      chk({name, " brk"},  o.brk,  brk);
      chk({name, " ovr"},  o.ovr,  ovr);
    end
    obs_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       m_perr;
    logic       m_ferr;
    logic       m_brk;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

    rx_if.i_ready = 1'b1;
    rst = 1'b1;
    wait_clk(5);
    chk("reset valid", rx_if.o_valid, 0);
    chk("reset data", rx_if.o_data, 0);
    chk("reset flags", {rx_if.o_parity_err, rx_if.o_frame_err, rx_if.o_break, rx_if.o_overrun}, 0);
    rst = 1'b0;
    wait_clk(BIT_CLK);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      wait_clk(2 * BIT_CLK);
      expect_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr,
                   vecs[i].exp_ferr, vecs[i].exp_brk, 1'b0);
    end

    // Short low glitch must be rejected, next frame still received
    rx = 1'b0;
    wait_clk(4 * 4);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    chk("glitch no frame", obs_q.size(), 0);
    chk("glitch valid", rx_if.o_valid, 0);
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_clk(2 * BIT_CLK);
    expect_frame("after glitch", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    // Overrun: consumer stalled across two frames
    rx_if.i_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    send_frame(8'h22, 1'b1, 1'b1);
    wait_clk(2 * BIT_CLK);
    chk("ovr valid held", rx_if.o_valid, 1);
    chk("ovr old data kept", rx_if.o_data, 8'h11);
    chk("ovr flag", rx_if.o_overrun, 1);
    rx_if.i_ready = 1'b1;
    wait_clk(1);
    rx_if.i_ready = 1'b0;
    wait_clk(2);
    chk("ovr valid cleared", rx_if.o_valid, 0);
    chk("ovr flag cleared", rx_if.o_overrun, 0);
    rx_if.i_ready = 1'b1;
    expect_frame("ovr handshake", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);

    // Break: line held low for 12 bit times
    rx = 1'b0;
    wait_clk(12 * BIT_CLK);
    expect_frame("break", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_clk(2 * BIT_CLK);
    chk("break no repeat", obs_q.size(), 0);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    send_frame(8'h5A, 1'b1, 1'b1);
    wait_clk(2 * BIT_CLK);
    expect_frame("after break", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of data bit 4 of frame 0x10
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    wait_clk(BIT_CLK / 2);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    wait_clk(12 * BIT_CLK);
    chk("reset midframe no frame", obs_q.size(), 0);
    chk("reset midframe valid", rx_if.o_valid, 0);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_clk(2 * BIT_CLK);
    expect_frame("after reset", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized frames against the frame-level rules
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom_range(0, 255));
      if (n == 0) d = 8'h00;
      p = ~(^d);
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 7) != 0);
      m_perr = ((^d) ^ p) == 1'b0;
      m_ferr = ~s;
      m_brk  = m_ferr && (d == 8'h00) && (p == 1'b0);
      send_frame(d, p, s);
      wait_clk(BIT_CLK * (1 + int'($urandom_range(0, 2))));
      expect_frame($sformatf("rand%0d", n), d, m_perr, m_ferr, m_brk, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
